forward_hazard_unit: RTL

FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

---
 rtl/fwd_pkg.sv | 29 ++
 rtl/fwd_match.sv | 33 +++
 rtl/forward_hazard_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fwd_pkg
// Brief    : Shared types, constants and helpers for the forwarding/hazard unit.
// Revision : 1.0 - initial release
// ============================================================================
package fwd_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } fsm_state_t;

    localparam int SEL_RF = 0;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_match.sv
`default_nettype none
// ============================================================================
// Module   : fwd_match
// Brief    : Priority forwarding select for a single source operand.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_match
    import fwd_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 5,
    parameter int SEL_W  = 2
) (
    input  logic [DEPTH-1:0]        stage_wb,
    input  logic [DEPTH*ADDR_W-1:0] stage_waddr,
    input  logic [ADDR_W-1:0]       src_addr,
    output logic [SEL_W-1:0]        sel
);

    // Walk oldest to youngest so the youngest matching stage is assigned last.
    always_comb begin
        sel = SEL_W'(SEL_RF);
        for (int k = DEPTH; k >= 1; k--) begin
            if (stage_wb[k-1] &&
                (stage_waddr[(k-1)*ADDR_W +: ADDR_W] != '0) &&
                (stage_waddr[(k-1)*ADDR_W +: ADDR_W] == src_addr)) begin
                sel = SEL_W'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/forward_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : forward_hazard_unit
// Brief    : Operand forwarding selects plus load-use stall/bubble control.
// Config   : FWD_STATS_EN adds saturating forward/stall statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module forward_hazard_unit
    import fwd_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 2,
    parameter int ADDR_W   = 5,
    parameter int LOAD_LAT = 1,
    parameter int STAT_W   = 16,
    localparam int SEL_W   = clog2(DEPTH + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [DEPTH-1:0]          stage_wb_i,
    input  logic [DEPTH*ADDR_W-1:0]   stage_waddr_i,
    input  logic [NUM_SRC*ADDR_W-1:0] ex_src_addr_i,
    input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr_i,
    input  logic                      id_valid_i,
    input  logic                      ex_memread_i,
    input  logic [ADDR_W-1:0]         ex_waddr_i,
    input  logic                      flush_i,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o,
    output logic                      stall_o,
    output logic                      bubble_o
`ifdef FWD_STATS_EN
    ,
    input  logic                      stat_clr_i,
    output logic [STAT_W-1:0]         stat_fwd_o,
    output logic [STAT_W-1:0]         stat_stall_o
`endif
);

    logic [NUM_SRC-1:0] w_fwd_active;

    generate
        for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
            fwd_match #(
                .DEPTH  (DEPTH),
                .ADDR_W (ADDR_W),
                .SEL_W  (SEL_W)
            ) u_match (
                .stage_wb    (stage_wb_i),
                .stage_waddr (stage_waddr_i),
                .src_addr    (ex_src_addr_i[g*ADDR_W +: ADDR_W]),
                .sel         (fwd_sel_o[g*SEL_W +: SEL_W])
            );
            assign w_fwd_active[g] = (fwd_sel_o[g*SEL_W +: SEL_W] != SEL_W'(SEL_RF));
        end
    endgenerate

    logic w_src_hit;
    logic w_hazard;

    always_comb begin
        w_src_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_addr_i[i*ADDR_W +: ADDR_W] == ex_waddr_i) begin
                w_src_hit = 1'b1;
            end
        end
    end

    assign w_hazard = id_valid_i && ex_memread_i && (ex_waddr_i != '0) && w_src_hit;

    fsm_state_t r_state;
    fsm_state_t w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    logic       w_stall;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Flush overrides everything; hazards are only sampled from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        if (flush_i) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hazard) begin
                        w_stall = 1'b1;
                        if (LOAD_LAT > 1) begin
                            w_state_nxt = STALL;
                            w_cnt_nxt   = 3'(LOAD_LAT - 1);
                        end
                    end
                end
                STALL: begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign stall_o  = w_stall && rst_i;
    assign bubble_o = w_stall && rst_i;

`ifdef FWD_STATS_EN
    localparam int c_SUM_W = STAT_W + 1;

    logic [1:0]         w_fwd_cnt;
    logic [STAT_W:0]    w_fwd_sum;
    logic [STAT_W:0]    w_stall_sum;
    logic [STAT_W-1:0]  r_stat_fwd;
    logic [STAT_W-1:0]  r_stat_stall;

    always_comb begin
        w_fwd_cnt = 2'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_fwd_cnt = w_fwd_cnt + {1'b0, w_fwd_active[i]};
        end
    end

    // One extra sum bit flags overflow so the counters can clamp at all-ones.
    assign w_fwd_sum   = {1'b0, r_stat_fwd} + c_SUM_W'(w_fwd_cnt);
    assign w_stall_sum = {1'b0, r_stat_stall} + c_SUM_W'(stall_o);

    always_ff @(posedge clk_i) begin
        if (!rst_i || stat_clr_i) begin
            r_stat_fwd   <= '0;
            r_stat_stall <= '0;
        end else begin
            r_stat_fwd   <= w_fwd_sum[STAT_W]   ? '1 : w_fwd_sum[STAT_W-1:0];
            r_stat_stall <= w_stall_sum[STAT_W] ? '1 : w_stall_sum[STAT_W-1:0];
        end
    end

    assign stat_fwd_o   = r_stat_fwd;
    assign stat_stall_o = r_stat_stall;
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^w_fwd_active;
`endif

endmodule
`default_nettype wire
